// File: rtl/fetch_stage_if.sv
// Fetch stage bus: redirect input, instruction memory port and IF/ID slot.
interface fetch_stage_if;
  localparam int unsigned XLEN = 32;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_ready;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_data;
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_plus4;
  logic            fetch_err;
  logic [XLEN-1:0] err_pc;
  logic [XLEN-1:0] instr_count;

  // Fetch stage side
  modport master (
    input  redirect_valid, redirect_pc, id_ready, imem_data,
    output imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
           fetch_err, err_pc, instr_count
  );

  // Environment side (execute, decode, instruction memory)
  modport slave (
    output redirect_valid, redirect_pc, id_ready, imem_data,
    input  imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
           fetch_err, err_pc, instr_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, IF/ID slot, redirect and fault halt.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 64
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_BYTES);
  localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);

  typedef enum logic [0:0] {ST_RUN, ST_HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ifpc_q, ifpc_d;
  logic [XLEN-1:0] ifpc4_q, ifpc4_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] errpc_q, errpc_d;
  logic [XLEN-1:0] count_q, count_d;
  logic            xfer_c;
  logic            slot_free_c;

  assign xfer_c      = valid_q && bus.id_ready;
  assign slot_free_c = !valid_q || xfer_c;

  // State register and pipeline slot
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
      ifpc4_q <= '0;
      err_q   <= 1'b0;
      errpc_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifpc4_q <= ifpc4_d;
      err_q   <= err_d;
      errpc_q <= errpc_d;
      count_q <= count_d;
    end
  end

  // Next state: redirect beats capture/stall; transfers count in any state
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    ifpc4_d = ifpc4_q;
    err_d   = err_q;
    errpc_d = errpc_q;
    count_d = count_q;

    if (xfer_c) count_d = count_q + XLEN'(1);

    unique case (state_q)
      ST_RUN: begin
        if (bus.redirect_valid) begin
          valid_d = 1'b0;
          if (bus.redirect_pc[1:0] == 2'b00) begin
            pc_d = bus.redirect_pc;
          end else begin
            state_d = ST_HALT;
            err_d   = 1'b1;
            errpc_d = bus.redirect_pc;
          end
        end else if (slot_free_c) begin
          if (pc_q < IMEM_LIMIT) begin
            instr_d = bus.imem_data;
            ifpc_d  = pc_q;
            ifpc4_d = pc_q + INSTR_BYTES;
            valid_d = 1'b1;
            pc_d    = pc_q + INSTR_BYTES;
          end else begin
            state_d = ST_HALT;
            err_d   = 1'b1;
            errpc_d = pc_q;
            valid_d = 1'b0;
          end
        end
      end
      ST_HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_valid    = valid_q;
  assign bus.if_instr    = instr_q;
  assign bus.if_pc       = ifpc_q;
  assign bus.if_pc_plus4 = ifpc4_q;
  assign bus.fetch_err   = err_q;
  assign bus.err_pc      = errpc_q;
  assign bus.instr_count = count_q;
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, byte address loaded into PC on reset.
REQ-002 Parameter IMEM_BYTES, 64, instruction memory size in bytes; valid fetch addresses are 0..IMEM_BYTES-4.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 redirect_valid  in  1  taken branch/jump from execute; PC must be replaced.
REQ-006 redirect_pc  in  32  redirect target byte address.
REQ-007 id_ready  in  1  decode can accept the IF/ID slot this cycle.
REQ-008 imem_addr  out  32  byte address to combinational instruction memory; equals PC.
REQ-009 imem_data  in  32  instruction word returned for imem_addr, same cycle.
REQ-010 if_valid  out  1  IF/ID slot holds an instruction.
REQ-011 if_instr  out  32  captured instruction word.
REQ-012 if_pc  out  32  address the instruction was fetched from.
REQ-013 if_pc_plus4  out  32  if_pc + 4, mod 2^32.
REQ-014 fetch_err  out  1  sticky fault flag; fetch halted.
REQ-015 err_pc  out  32  faulting address.
REQ-016 instr_count  out  32  number of IF->ID transfers since reset.

Function
REQ-017 States RUN and HALT; reset enters RUN; HALT exits only via rst.
REQ-018 Transfer = if_valid && id_ready; slot free = !if_valid || transfer.
REQ-019 RUN, redirect_valid=1, redirect_pc[1:0]=0: PC <= redirect_pc; if_valid <= 0; no capture.
REQ-020 RUN, redirect_valid=1, redirect_pc[1:0]!=0: state <= HALT; fetch_err <= 1; err_pc <= redirect_pc; if_valid <= 0; PC holds.
REQ-021 RUN, no redirect, slot free, PC < IMEM_BYTES: if_instr <= imem_data; if_pc <= PC; if_pc_plus4 <= PC+4; if_valid <= 1; PC <= PC+4.
REQ-022 RUN, no redirect, slot free, PC >= IMEM_BYTES: state <= HALT; fetch_err <= 1; err_pc <= PC; if_valid <= 0; no capture.
REQ-023 RUN, no redirect, slot not free (stall): PC, if_* and imem_addr hold.
REQ-024 Redirect takes priority over stall and capture; a transfer in the redirect cycle still completes and counts.
REQ-025 instr_count increments by 1 on every transfer in any state; wraps 2^32-1 -> 0.
REQ-026 HALT: PC, if_* held except if_valid=0; redirect_valid and id_ready ignored.
REQ-027 PC arithmetic is 32-bit unsigned; 32'hFFFF_FFFC + 4 = 0.
REQ-028 Latency: instruction at PC appears on if_* one edge after the cycle PC is presented; one instruction per cycle when id_ready=1 continuously.

Reset
REQ-029 rst=1 at an edge: PC <= RESET_PC; if_valid, if_instr, if_pc, if_pc_plus4, fetch_err, err_pc, instr_count <= 0; state <= RUN.
REQ-030 rst overrides redirect, stall and HALT in the same cycle; mid-stream reset discards the IF/ID slot.
REQ-031 First edge with rst=0 captures mem[RESET_PC]; if_valid=1 after it.

Verification
REQ-032 Reset then id_ready=1, no redirect -> if_pc 0,4,8,12 on successive cycles, if_pc_plus4 = if_pc+4, instr_count counts 1,2,3.
REQ-033 if_valid=1, if_pc=8, id_ready=0 for 3 cycles -> if_* held, imem_addr=12, instr_count unchanged; id_ready=1 -> if_pc=12 next.
REQ-034 redirect_valid=1, redirect_pc=44 while if_pc=36, id_ready=1 -> next cycle if_valid=0, imem_addr=44, instr_count+1; following cycle if_pc=44.
REQ-035 redirect_valid=1, redirect_pc=56, id_ready=0 same cycle -> if_valid=0, imem_addr=56, instr_count unchanged.
REQ-036 redirect_pc=32'h3A -> fetch_err=1, err_pc=32'h3A, if_valid=0 for 10 cycles despite inputs; rst -> fetch_err=0, imem_addr=0.
REQ-037 Sequential run with IMEM_BYTES=64 -> last valid if_pc=60; at PC=64 fetch_err=1, err_pc=64, if_valid=0.
